scan_compositor: RTL and testbench
==================================

# scan_compositor

Parametrised full-screen scan-and-compose engine for the VGA adapter path. On each frame request it walks every pixel of an H_RES×V_RES screen exactly once in raster order, resolves the colour from N_SPRITES point sprites, two bullet-grid layers and a background colour by fixed priority, and emits one registered (x, y, colour, plot) write per cycle. It sits between the game FSM and the VGA adapter write port. It replaces the single-user/single-enemy datapath with configurable sprite count, screen size, colour depth and grid orientation, plus a start/busy/done handshake.

## Interface
- H_RES, 160, screen width in pixels
- V_RES, 120, screen height in pixels
- XW, 8, x coordinate width; must satisfy 2^XW ≥ H_RES
- YW, 7, y coordinate width; must satisfy 2^YW ≥ V_RES
- N_SPRITES, 2, number of point sprites; minimum 1
- CW, 3, colour width
- FLIP_B, 1, when 1, grid_b is read vertically mirrored

- clk  in  1  system clock; all logic on the rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- clear_req  in  1  sampled with start; 1 = paint the whole frame bg_colour
- sprite_en  in  N_SPRITES  per-sprite enable
- sprite_x  in  N_SPRITES*XW  packed x positions; sprite i at [i*XW +: XW]
- sprite_y  in  N_SPRITES*YW  packed y positions
- sprite_colour  in  N_SPRITES*CW  packed sprite colours
- grid_a  in  H_RES*V_RES  bullet layer A; bit y*H_RES+x
- grid_b  in  H_RES*V_RES  bullet layer B; bit y*H_RES+x, or (V_RES-1-y)*H_RES+x when FLIP_B=1
- grid_a_colour, grid_b_colour, bg_colour  in  CW each  layer colours
- x  out  XW  pixel x
- y  out  YW  pixel y
- colour  out  CW  pixel colour
- plot  out  1  write strobe for (x, y, colour)
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, SCAN. Internal counters sx (XW bits), sy (YW bits), frame-mode flag clr, and flag clear_pending.
- Reset (resetn=0 at an edge): state=IDLE; sx=sy=0; x=0, y=0, colour=0, plot=0, busy=0, done=0; clear_pending=1. Reset during SCAN aborts the frame immediately with no done.
- IDLE with start=1: go to SCAN; sx=sy=0; clr = clear_req OR clear_pending. Start in SCAN is ignored and does not queue.
- SCAN, every cycle: output registers take x=sx, y=sy, colour=resolve(sx,sy), plot=1. Then the counters advance. sx increments. At sx=H_RES-1, sx becomes 0 and sy increments. At (H_RES-1, V_RES-1), the state goes to IDLE. Coordinates never reach H_RES or V_RES.
- resolve priority, highest first:
  - clr → bg_colour.
  - The lowest-index enabled sprite i with sprite_x[i]==sx and sprite_y[i]==sy → sprite_colour[i].
  - grid_a bit set → grid_a_colour.
  - grid_b bit set, with FLIP_B indexing → grid_b_colour.
  - Otherwise bg_colour.
- Sprites with coordinates ≥ H_RES or ≥ V_RES never match and are never wrapped.
- Layer inputs are read live each cycle. The caller holds them stable during a frame if a coherent image is required.
- Frame completion: done=1 for the one cycle after the last plot. If clr was set, clear_pending is cleared at that point. An aborted clear frame leaves clear_pending=1.
- Outside SCAN output: plot=0; x, y and colour hold their last values.

## Timing
- start sampled at edge k → busy=1 and SCAN from edge k.
- First plot (0,0) at edge k+1. Pixel (px,py) is output at edge k+1+py*H_RES+px.
- Last plot (H_RES-1, V_RES-1) at edge k+H_RES*V_RES.
- At edge k+H_RES*V_RES+1: plot=0, busy=0, done=1.
- Earliest restart: start high at the done edge is accepted, because the state is already IDLE there. Frame period is H_RES*V_RES+1 cycles.
- Exactly one plot per pixel per frame, with no gaps and no duplicates. Throughput is one pixel per cycle.

## Test plan
- Reset then start with clear_req=0: the first frame is forced clear, so all 19200 plots are bg_colour=3'b000. done occurs 19201 cycles after start. A second frame then shows layers.
- Sprite 0 at (5,3) red=3'b100, sprite 1 at (5,3) blue=3'b001, both enabled: pixel (5,3) is 3'b100. Disabling sprite 0 gives 3'b001. Every other pixel is bg.
- grid_a bit 3*160+7 set, and grid_b bit for (7,3) set via FLIP_B mirror row 116: pixel (7,3) is grid_a_colour. Clearing grid_a gives grid_b_colour.
- Sprite at (200,3), which is out of range: no pixel takes the sprite colour, and x never exceeds 159, y never exceeds 119.
- Assert start repeatedly mid-frame: the frame completes with exactly 19200 plots and one done pulse. A start on the done cycle begins the next frame with (0,0) one cycle later.
- resetn low at pixel (80,60): the next cycle has plot=0, busy=0, done never pulses, and clear_pending=1. The next frame is all bg.

Source files
------------

// File: rtl/scan_compositor.sv
// rtl/scan_compositor.sv - full-screen raster scan that composes sprites, two bullet grids and background
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   start, clear_req             frame request (sampled in IDLE) and clear-frame request
//   sprite_en/x/y/colour         packed per-sprite enable, position and colour
//   grid_a, grid_b               bullet layers, bit y*H_RES+x (grid_b row mirrored when FLIP_B=1)
//   grid_a_colour, grid_b_colour, bg_colour   layer colours
//   x, y, colour, plot           registered pixel write toward the VGA adapter
//   busy, done                   frame in progress / one-cycle frame-complete pulse
module scan_compositor #(
    parameter int H_RES     = 160,
    parameter int V_RES     = 120,
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int N_SPRITES = 2,
    parameter int CW        = 3,
    parameter int FLIP_B    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    clear_req,
    input  logic [N_SPRITES-1:0]    sprite_en,
    input  logic [N_SPRITES*XW-1:0] sprite_x,
    input  logic [N_SPRITES*YW-1:0] sprite_y,
    input  logic [N_SPRITES*CW-1:0] sprite_colour,
    input  logic [H_RES*V_RES-1:0]  grid_a,
    input  logic [H_RES*V_RES-1:0]  grid_b,
    input  logic [CW-1:0]           grid_a_colour,
    input  logic [CW-1:0]           grid_b_colour,
    input  logic [CW-1:0]           bg_colour,
    output logic [XW-1:0]           x,
    output logic [YW-1:0]           y,
    output logic [CW-1:0]           colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);
    localparam int IW = $clog2(H_RES * V_RES);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t        state;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic          clr;
    logic          clear_pending;
    logic          done_pend;      // last pixel was plotted; done fires on the next edge

    logic          spr_hit;
    logic [CW-1:0] spr_col;
    logic [YW-1:0] row_b;
    logic [IW-1:0] idx_a;
    logic [IW-1:0] idx_b;
    logic [CW-1:0] pix;
    logic          pend_eff;
    logic          last_px;

    assign row_b   = (FLIP_B != 0) ? (YW'(V_RES - 1) - sy) : sy;
    assign idx_a   = IW'(sy) * IW'(H_RES) + IW'(sx);
    assign idx_b   = IW'(row_b) * IW'(H_RES) + IW'(sx);
    assign last_px = (sx == XW'(H_RES - 1)) && (sy == YW'(V_RES - 1));

    // A clear frame finishing on this very edge must not force the next
    // back-to-back frame clear as well.
    assign pend_eff = clear_pending & ~(done_pend & clr);

    // Walk downward so the lowest-index matching sprite wins.
    always_comb begin
        spr_hit = 1'b0;
        spr_col = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (sprite_en[i] && (sprite_x[i*XW +: XW] == sx) && (sprite_y[i*YW +: YW] == sy)) begin
                spr_hit = 1'b1;
                spr_col = sprite_colour[i*CW +: CW];
            end
        end
    end

    always_comb begin
        pix = bg_colour;
        if (clr)
            pix = bg_colour;
        else if (spr_hit)
            pix = spr_col;
        else if (grid_a[idx_a])
            pix = grid_a_colour;
        else if (grid_b[idx_b])
            pix = grid_b_colour;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            sx            <= '0;
            sy            <= '0;
            x             <= '0;
            y             <= '0;
            colour        <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            clr           <= 1'b0;
            clear_pending <= 1'b1;
            done_pend     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    plot      <= 1'b0;
                    done      <= done_pend;
                    done_pend <= 1'b0;
                    if (done_pend && clr)
                        clear_pending <= 1'b0;
                    busy <= start;
                    if (start) begin
                        state <= S_SCAN;
                        sx    <= '0;
                        sy    <= '0;
                        clr   <= clear_req | pend_eff;
                    end
                end
                S_SCAN: begin
                    x      <= sx;
                    y      <= sy;
                    colour <= pix;
                    plot   <= 1'b1;
                    done   <= 1'b0;
                    if (last_px) begin
                        state     <= S_IDLE;
                        sx        <= '0;
                        sy        <= '0;
                        done_pend <= 1'b1;
                    end else if (sx == XW'(H_RES - 1)) begin
                        sx <= '0;
                        sy <= sy + 1'b1;
                    end else begin
                        sx <= sx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_compositor.sv
// tb/tb_scan_compositor.sv - randomized self-checking bench for scan_compositor
module tb_scan_compositor;
    localparam int H  = 20;
    localparam int V  = 12;
    localparam int XW = 8;
    localparam int YW = 5;
    localparam int N  = 3;
    localparam int CW = 3;
    localparam int HV = H * V;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic            clear_req = 1'b0;
    logic [N-1:0]    sprite_en = '0;
    logic [N*XW-1:0] sprite_x = '0;
    logic [N*YW-1:0] sprite_y = '0;
    logic [N*CW-1:0] sprite_colour = '0;
    logic [HV-1:0]   grid_a = '0;
    logic [HV-1:0]   grid_b = '0;
    logic [CW-1:0]   grid_a_colour = '0;
    logic [CW-1:0]   grid_b_colour = '0;
    logic [CW-1:0]   bg_colour = '0;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic            plot, busy, done;

    scan_compositor #(
        .H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .N_SPRITES(N), .CW(CW), .FLIP_B(1)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .clear_req(clear_req),
        .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_colour(sprite_colour), .grid_a(grid_a), .grid_b(grid_b),
        .grid_a_colour(grid_a_colour), .grid_b_colour(grid_b_colour), .bg_colour(bg_colour),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit pending;

    // Scene model, kept in screen coordinates.
    bit            m_en[N];
    int            m_x[N];
    int            m_y[N];
    logic [CW-1:0] m_c[N];
    bit            m_ga[V][H];
    bit            m_gb[V][H];
    logic [CW-1:0] m_acol, m_bcol, m_bg;

    function automatic logic [CW-1:0] ref_colour(int px, int py, bit c);
        if (c) return m_bg;
        for (int i = 0; i < N; i++)
            if (m_en[i] && m_x[i] == px && m_y[i] == py) return m_c[i];
        if (m_ga[py][px]) return m_acol;
        if (m_gb[py][px]) return m_bcol;
        return m_bg;
    endfunction

    task automatic apply_layers();
        for (int i = 0; i < N; i++) begin
            sprite_en[i]               = m_en[i];
            sprite_x[i*XW +: XW]       = XW'(m_x[i]);
            sprite_y[i*YW +: YW]       = YW'(m_y[i]);
            sprite_colour[i*CW +: CW]  = m_c[i];
        end
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) begin
                grid_a[r*H + c]       = m_ga[r][c];
                grid_b[(V-1-r)*H + c] = m_gb[r][c];
            end
        grid_a_colour = m_acol;
        grid_b_colour = m_bcol;
        bg_colour     = m_bg;
    endtask

    task automatic clear_layers();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_c[i] = '0;
        end
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) begin
                m_ga[r][c] = 0; m_gb[r][c] = 0;
            end
        m_acol = '0; m_bcol = '0; m_bg = '0;
    endtask

    task automatic random_layers();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 1'($urandom_range(0, 3) != 0);
            m_x[i]  = $urandom_range(0, H + 3);
            m_y[i]  = $urandom_range(0, V + 2);
            m_c[i]  = CW'($urandom);
        end
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++) begin
                m_ga[r][c] = ($urandom_range(0, 3) == 0);
                m_gb[r][c] = ($urandom_range(0, 3) == 0);
            end
        m_acol = CW'($urandom);
        m_bcol = CW'($urandom);
        m_bg   = CW'($urandom);
    endtask

    // mode 0: clean; mode 1: random start pulses mid-frame; mode 2: start held through done.
    // chained: the start edge was the previous frame's done edge.
    task automatic run_frame(input bit clr_req, input int mode, input bit chained);
        bit            c;
        int            bad;
        int            bad_px, bad_py;
        logic [CW-1:0] e, bad_got, bad_exp;
        bit            restarted;
        c = clr_req | pending;
        bad = 0; bad_px = 0; bad_py = 0; bad_got = '0; bad_exp = '0;
        if (chained) begin
            start = 1'b0;
        end else begin
            @(negedge clk);
            apply_layers();
            clear_req = clr_req;
            start = 1'b1;
            @(posedge clk); #1;
            start = (mode == 2);
            checks++;
            if (busy !== 1'b1 || plot !== 1'b0) begin
                errors++;
                $display("FAIL start_ack busy=%b plot=%b required busy=1 plot=0", busy, plot);
            end
        end
        for (int p = 0; p < HV; p++) begin
            if (mode == 1) start = (p < HV - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            e = ref_colour(p % H, p / H, c);
            if (plot !== 1'b1 || x !== XW'(p % H) || y !== YW'(p / H) || colour !== e ||
                busy !== 1'b1 || done !== 1'b0 || x >= H || y >= V) begin
                if (bad == 0) begin
                    bad_px = p % H; bad_py = p / H; bad_got = colour; bad_exp = e;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_pixels bad=%0d required 0 (first at %0d,%0d colour=%0h required %0h)",
                     bad, bad_px, bad_py, bad_got, bad_exp);
        end
        restarted = (mode == 2);
        @(posedge clk); #1;
        e = ref_colour(H - 1, V - 1, c);
        checks++;
        if (done !== 1'b1 || plot !== 1'b0 || busy !== restarted ||
            x !== XW'(H - 1) || y !== YW'(V - 1) || colour !== e) begin
            errors++;
            $display("FAIL done_edge done=%b plot=%b busy=%b x=%0d y=%0d colour=%0h required 1 0 %b %0d %0d %0h",
                     done, plot, busy, x, y, colour, restarted, H - 1, V - 1, e);
        end
        if (c) pending = 0;
        if (!restarted) begin
            start = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_single done=%b plot=%b busy=%b required 0 0 0", done, plot, busy);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_layers();
        apply_layers();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags plot=%b busy=%b done=%b required 0 0 0", plot, busy, done);
        end
        checks++;
        if (x !== '0 || y !== '0 || colour !== '0) begin
            errors++;
            $display("FAIL reset_coords x=%0d y=%0d colour=%0h required 0 0 0", x, y, colour);
        end
        @(negedge clk);
        resetn = 1'b1;
        pending = 1;
    endtask

    task automatic test_forced_clear();
        random_layers();
        run_frame(1'b0, 0, 1'b0);
        run_frame(1'b0, 0, 1'b0);
    endtask

    task automatic test_sprites();
        clear_layers();
        m_en[0] = 1; m_x[0] = 5; m_y[0] = 3; m_c[0] = 3'b100;
        m_en[1] = 1; m_x[1] = 5; m_y[1] = 3; m_c[1] = 3'b001;
        run_frame(1'b0, 0, 1'b0);
        m_en[0] = 0;
        run_frame(1'b0, 0, 1'b0);
    endtask

    task automatic test_grids();
        clear_layers();
        m_ga[3][7] = 1; m_gb[3][7] = 1;
        m_acol = 3'b010; m_bcol = 3'b101; m_bg = 3'b000;
        run_frame(1'b0, 0, 1'b0);
        m_ga[3][7] = 0;
        run_frame(1'b0, 0, 1'b0);
    endtask

    task automatic test_out_of_range();
        clear_layers();
        m_en[0] = 1; m_x[0] = 200;   m_y[0] = 3;     m_c[0] = 3'b111;
        m_en[1] = 1; m_x[1] = 5;     m_y[1] = V;     m_c[1] = 3'b110;
        m_en[2] = 1; m_x[2] = H;     m_y[2] = 0;     m_c[2] = 3'b011;
        m_bg = 3'b001;
        run_frame(1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        random_layers();
        run_frame(1'b0, 1, 1'b0);
        run_frame(1'b0, 2, 1'b0);
        run_frame(1'b0, 0, 1'b1);
    endtask

    task automatic test_reset_abort();
        int idx;
        int seen_done;
        random_layers();
        m_bg = 3'b110;
        idx = 6 * H + 10;
        @(negedge clk);
        apply_layers();
        clear_req = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        clear_req = 1'b0;
        repeat (idx + 1) @(posedge clk);
        #1;
        checks++;
        if (plot !== 1'b1 || x !== XW'(10) || y !== YW'(6)) begin
            errors++;
            $display("FAIL abort_point plot=%b x=%0d y=%0d required 1 10 6", plot, x, y);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs plot=%b busy=%b done=%b required 0 0 0", plot, busy, done);
        end
        @(negedge clk);
        resetn = 1'b1;
        pending = 1;
        seen_done = 0;
        repeat (HV) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || plot !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done cycles_with_activity=%0d required 0", seen_done);
        end
        run_frame(1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            random_layers();
            run_frame(1'($urandom_range(0, 1)), 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_forced_clear();
        test_sprites();
        test_grids();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
